// File: rtl/vmem_rect_fill_if.sv
// Command, video-memory write and status signals between the rectangle-fill
// engine (slave) and the processor/arbiter side (master).
interface vmem_rect_fill_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 15
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [6:0]        CMD_X;
    logic [6:0]        CMD_Y;
    logic [7:0]        CMD_W;
    logic [7:0]        CMD_H;
    logic [DATA_W-1:0] CMD_COLOR;
    logic              ABORT;
    logic              VMEM_WE;
    logic [ADDR_W-1:0] VMEM_ADDR;
    logic [DATA_W-1:0] VMEM_WDATA;
    logic              VMEM_GRANT;
    logic              BUSY;
    logic              DONE;
    logic              ABORTED;

    modport master (
        output CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR, ABORT, VMEM_GRANT,
        input  CMD_READY, VMEM_WE, VMEM_ADDR, VMEM_WDATA, BUSY, DONE, ABORTED
    );

    modport slave (
        input  CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR, ABORT, VMEM_GRANT,
        output CMD_READY, VMEM_WE, VMEM_ADDR, VMEM_WDATA, BUSY, DONE, ABORTED
    );
endinterface

// File: rtl/vmem_rect_fill.sv
// Rectangle-fill engine: clips a command to the 128x124 screen and writes it
// pixel by pixel in raster order into the video-memory write port.
module vmem_rect_fill #(
    parameter int unsigned H_PIXELS = 128,
    parameter int unsigned V_LINES  = 124,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 15
) (
    input logic             CLK,
    input logic             RESET_N,
    vmem_rect_fill_if.slave bus
);
    localparam int unsigned X_W = 7;
    localparam int unsigned Y_W = 7;

    typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;

    state_t       state;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic [X_W-1:0] x_start;
    logic [X_W:0]   x_end;
    logic [Y_W:0]   y_end;

    // Clip window from the command fields; 9-bit sums cannot wrap.
    logic [8:0]     x_sum_c;
    logic [8:0]     y_sum_c;
    logic [X_W:0]   x_end_c;
    logic [Y_W:0]   y_end_c;
    logic           empty_c;

    assign x_sum_c = 9'(bus.CMD_X) + 9'(bus.CMD_W);
    assign y_sum_c = 9'(bus.CMD_Y) + 9'(bus.CMD_H);
    assign x_end_c = (x_sum_c > 9'(H_PIXELS)) ? (X_W+1)'(H_PIXELS) : (X_W+1)'(x_sum_c);
    assign y_end_c = (y_sum_c > 9'(V_LINES))  ? (Y_W+1)'(V_LINES)  : (Y_W+1)'(y_sum_c);
    assign empty_c = (bus.CMD_W == 8'd0) || (bus.CMD_H == 8'd0) ||
                     ({1'b0, bus.CMD_X} >= (X_W+1)'(H_PIXELS)) ||
                     ({1'b0, bus.CMD_Y} >= (Y_W+1)'(V_LINES));

    // Raster stepping: end of row and end of rectangle.
    logic [X_W:0]   nx_c;
    logic [Y_W:0]   ny_c;
    logic           row_end_c;
    logic           last_c;

    assign nx_c      = {1'b0, cur_x} + (X_W+1)'(1);
    assign ny_c      = {1'b0, cur_y} + (Y_W+1)'(1);
    assign row_end_c = (nx_c == x_end);
    assign last_c    = row_end_c && (ny_c == y_end);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= IDLE;
            cur_x          <= '0;
            cur_y          <= '0;
            x_start        <= '0;
            x_end          <= '0;
            y_end          <= '0;
            bus.CMD_READY  <= 1'b1;
            bus.VMEM_WE    <= 1'b0;
            bus.VMEM_ADDR  <= '0;
            bus.VMEM_WDATA <= '0;
            bus.BUSY       <= 1'b0;
            bus.DONE       <= 1'b0;
            bus.ABORTED    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CMD_VALID && bus.CMD_READY) begin
                        cur_x         <= bus.CMD_X;
                        cur_y         <= bus.CMD_Y;
                        x_start       <= bus.CMD_X;
                        x_end         <= x_end_c;
                        y_end         <= y_end_c;
                        bus.CMD_READY <= 1'b0;
                        bus.BUSY      <= 1'b1;
                        if (empty_c) begin
                            state    <= FINISH;
                            bus.DONE <= 1'b1;
                        end else begin
                            state          <= FILL;
                            bus.VMEM_WE    <= 1'b1;
                            bus.VMEM_ADDR  <= ADDR_W'({bus.CMD_Y, bus.CMD_X});
                            bus.VMEM_WDATA <= bus.CMD_COLOR;
                        end
                    end
                end
                FILL: begin
                    // A grant coinciding with ABORT still completes that write.
                    if (bus.ABORT || (bus.VMEM_GRANT && last_c)) begin
                        state       <= FINISH;
                        bus.VMEM_WE <= 1'b0;
                        bus.DONE    <= 1'b1;
                        bus.ABORTED <= bus.ABORT;
                    end else if (bus.VMEM_GRANT) begin
                        if (row_end_c) begin
                            cur_x         <= x_start;
                            cur_y         <= ny_c[Y_W-1:0];
                            bus.VMEM_ADDR <= ADDR_W'({ny_c[Y_W-1:0], x_start});
                        end else begin
                            cur_x         <= nx_c[X_W-1:0];
                            bus.VMEM_ADDR <= ADDR_W'({cur_y, nx_c[X_W-1:0]});
                        end
                    end
                end
                FINISH: begin
                    state         <= IDLE;
                    bus.DONE      <= 1'b0;
                    bus.ABORTED   <= 1'b0;
                    bus.BUSY      <= 1'b0;
                    bus.CMD_READY <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vmem_rect_fill.sv
// Directed bench for vmem_rect_fill: table of clipped fills plus stall,
// abort and reset-mid-fill sequences; outputs sampled on the falling edge.
module tb_vmem_rect_fill;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    vmem_rect_fill_if #(.ADDR_W(14), .DATA_W(15)) bus ();

    vmem_rect_fill #(.H_PIXELS(128), .V_LINES(124), .ADDR_W(14), .DATA_W(15)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    typedef struct {
        logic [6:0]  x;
        logic [6:0]  y;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [14:0] color;
        int          n;
        logic [13:0] first;
        logic [13:0] last;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [13:0] cap [0:511];
    int          cap_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge CLK);
        while (!bus.CMD_READY && k < 50) begin
            @(negedge CLK);
            k++;
        end
        check("cmd_ready_wait", 32'(bus.CMD_READY), 32'd1);
    endtask

    // Issues one command; returns at the negedge right after the accepting edge.
    task automatic start_cmd(input logic [6:0] x, input logic [6:0] y, input logic [7:0] w,
                             input logic [7:0] h, input logic [14:0] c);
        wait_ready();
        bus.CMD_VALID = 1'b1;
        bus.CMD_X = x; bus.CMD_Y = y; bus.CMD_W = w; bus.CMD_H = h; bus.CMD_COLOR = c;
        @(posedge CLK);
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        // Scramble fields: the engine must have latched them already.
        bus.CMD_X = ~x; bus.CMD_Y = ~y; bus.CMD_W = ~w; bus.CMD_H = ~h; bus.CMD_COLOR = ~c;
    endtask

    task automatic run_cmd(input string name, input logic [6:0] x, input logic [6:0] y,
                           input logic [7:0] w, input logic [7:0] h, input logic [14:0] c,
                           input int exp_n, input logic [13:0] exp_first, input logic [13:0] exp_last);
        int cyc = 1;
        int done_at = 0;
        int bad_data = 0;
        logic ab = 1'b0;
        cap_n = 0;
        start_cmd(x, y, w, h, c);
        while (cyc < 400 && done_at == 0) begin
            if (bus.DONE) begin
                done_at = cyc;
                ab = bus.ABORTED;
            end else if (bus.VMEM_WE && bus.VMEM_GRANT) begin
                if (cap_n < 512) cap[cap_n] = bus.VMEM_ADDR;
                if (bus.VMEM_WDATA !== c) bad_data++;
                cap_n++;
            end
            @(negedge CLK);
            cyc++;
        end
        check({name, "_nwrites"}, 32'(cap_n), 32'(exp_n));
        check({name, "_done_cycle"}, 32'(done_at), 32'(exp_n + 1));
        check({name, "_aborted"}, 32'(ab), 32'd0);
        check({name, "_bad_data"}, 32'(bad_data), 32'd0);
        if (exp_n > 0 && cap_n > 0) begin
            check({name, "_first"}, 32'(cap[0]), 32'(exp_first));
            check({name, "_last"}, 32'(cap[cap_n - 1]), 32'(exp_last));
        end
        check({name, "_ready_after"}, 32'(bus.CMD_READY), 32'd1);
        check({name, "_done_clear"}, 32'(bus.DONE), 32'd0);
    endtask

    initial begin
        vec_t        vecs [0:8];
        logic [13:0] exp1 [0:5];
        int          nw;
        int          dseen;

        vecs[0] = '{7'd2,   7'd3,   8'd3,   8'd2,   15'h7C00, 6,   14'h0182, 14'h0204};
        vecs[1] = '{7'd126, 7'd122, 8'd10,  8'd10,  15'h03E0, 4,   14'h3D7E, 14'h3DFF};
        vecs[2] = '{7'd5,   7'd5,   8'd0,   8'd3,   15'h001F, 0,   14'h0000, 14'h0000};
        vecs[3] = '{7'd5,   7'd5,   8'd3,   8'd0,   15'h001F, 0,   14'h0000, 14'h0000};
        vecs[4] = '{7'd0,   7'd124, 8'd4,   8'd4,   15'h1234, 0,   14'h0000, 14'h0000};
        vecs[5] = '{7'd127, 7'd123, 8'd255, 8'd255, 15'h5555, 1,   14'h3DFF, 14'h3DFF};
        vecs[6] = '{7'd100, 7'd0,   8'd200, 8'd1,   15'h2AAA, 28,  14'h0064, 14'h007F};
        vecs[7] = '{7'd0,   7'd0,   8'd1,   8'd1,   15'h7FFF, 1,   14'h0000, 14'h0000};
        vecs[8] = '{7'd5,   7'd0,   8'd1,   8'd3,   15'h0421, 3,   14'h0005, 14'h0105};
        exp1[0] = 14'h0182; exp1[1] = 14'h0183; exp1[2] = 14'h0184;
        exp1[3] = 14'h0202; exp1[4] = 14'h0203; exp1[5] = 14'h0204;

        bus.CMD_VALID = 1'b0; bus.CMD_X = '0; bus.CMD_Y = '0; bus.CMD_W = '0; bus.CMD_H = '0;
        bus.CMD_COLOR = '0; bus.ABORT = 1'b0; bus.VMEM_GRANT = 1'b1;

        repeat (2) @(negedge CLK);
        check("rst_ready", 32'(bus.CMD_READY), 32'd1);
        check("rst_we", 32'(bus.VMEM_WE), 32'd0);
        check("rst_addr", 32'(bus.VMEM_ADDR), 32'd0);
        check("rst_wdata", 32'(bus.VMEM_WDATA), 32'd0);
        check("rst_busy_done_ab", 32'({bus.BUSY, bus.DONE, bus.ABORTED}), 32'd0);
        RESET_N = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                    vecs[i].color, vecs[i].n, vecs[i].first, vecs[i].last);
        end

        // Full address list of the basic 3x2 fill.
        run_cmd("list", 7'd2, 7'd3, 8'd3, 8'd2, 15'h7C00, 6, 14'h0182, 14'h0204);
        for (int i = 0; i < 6; i++) check($sformatf("list_addr%0d", i), 32'(cap[i]), 32'(exp1[i]));

        // Grant withheld for three cycles on the first pixel of a 2x1 fill at (4,1).
        bus.VMEM_GRANT = 1'b0;
        start_cmd(7'd4, 7'd1, 8'd2, 8'd1, 15'h0ABC);
        nw = 0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("stall_we%0d", k), 32'(bus.VMEM_WE), 32'd1);
            check($sformatf("stall_addr%0d", k), 32'(bus.VMEM_ADDR), 32'h84);
            if (k == 4) bus.VMEM_GRANT = 1'b1;
            if (bus.VMEM_WE && bus.VMEM_GRANT) nw++;
            if (k < 4) @(negedge CLK);
        end
        @(negedge CLK);
        check("stall_addr2", 32'(bus.VMEM_ADDR), 32'h85);
        if (bus.VMEM_WE && bus.VMEM_GRANT) nw++;
        @(negedge CLK);
        check("stall_nwrites", 32'(nw), 32'd2);
        check("stall_done", 32'({bus.DONE, bus.ABORTED, bus.VMEM_WE}), 32'b100);

        // Abort on the edge of the 5th granted write of a 4x4 fill at (10,20).
        start_cmd(7'd10, 7'd20, 8'd4, 8'd4, 15'h0F0F);
        nw = 0;
        for (int k = 1; k <= 5; k++) begin
            if (bus.VMEM_WE && bus.VMEM_GRANT) nw++;
            if (k == 5) begin
                check("abort_last_addr", 32'(bus.VMEM_ADDR), 32'hA8A);
                bus.ABORT = 1'b1;
            end
            @(negedge CLK);
        end
        bus.ABORT = 1'b0;
        check("abort_nwrites", 32'(nw), 32'd5);
        check("abort_done_ab", 32'({bus.DONE, bus.ABORTED}), 32'b11);
        check("abort_we_busy", 32'({bus.VMEM_WE, bus.BUSY}), 32'b01);
        @(negedge CLK);
        check("abort_clear", 32'({bus.DONE, bus.ABORTED, bus.CMD_READY, bus.BUSY}), 32'b0010);

        // ABORT held high while idle must not affect the next fill.
        bus.ABORT = 1'b1;
        repeat (2) @(negedge CLK);
        bus.ABORT = 1'b0;
        run_cmd("post_idle_abort", 7'd0, 7'd1, 8'd2, 8'd1, 15'h0001, 2, 14'h0080, 14'h0081);

        // Reset in the middle of a fill.
        start_cmd(7'd0, 7'd0, 8'd4, 8'd4, 15'h3333);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_we", 32'(bus.VMEM_WE), 32'd0);
        check("mid_rst_addr", 32'(bus.VMEM_ADDR), 32'd0);
        check("mid_rst_wdata", 32'(bus.VMEM_WDATA), 32'd0);
        check("mid_rst_status", 32'({bus.CMD_READY, bus.BUSY, bus.DONE, bus.ABORTED}), 32'b1000);
        dseen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (bus.DONE || bus.VMEM_WE) dseen++;
        end
        RESET_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (bus.DONE || bus.VMEM_WE) dseen++;
        end
        check("mid_rst_no_done", 32'(dseen), 32'd0);
        run_cmd("after_rst", 7'd0, 7'd0, 8'd1, 8'd1, 15'h7E57, 1, 14'h0000, 14'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
